cg_phase_sequencer: RTL and testbench
=====================================

// Module: cg_phase_sequencer
// PURPOSE
// Parametrised address/phase sequencer for the conjugate-gradient solver datapath. Runs a full CG
// iteration as an explicit FSM: A*p, p.Ap, x/r update, r.r, p update. Drives read/write addresses
// and write enables for the A, P, AP, X and R memories. Counts iterations and halts on convergence or
// on the iteration limit. Sits between the top-level start/halt control and the cluster/ALU datapath.
// PARAMETERS
// NO_OF_UNITS      8   vector elements per memory line (parallel units)
// N_EQUATIONS      19  equations in the system
// N_CLUSTERS       40  A-matrix rows (clusters) read per A*p phase
// ADDR_W           20  width of every memory address
// MAX_ITER         20  iteration limit (>=1)
// ITER_W           11  iteration counter width
// derived LINES = (N_EQUATIONS+NO_OF_UNITS-1)/NO_OF_UNITS (exact ceil; no extra line when divisible)
// PORTS
// clk          in   1       clock
// reset        in   1       synchronous, active-high
// start        in   1       begin solve; honoured only in IDLE or DONE
// stall        in   1       datapath back-pressure; blocks read issue this cycle
// res_valid    in   1       one datapath result for the current phase
// converged    in   1       residual below threshold; sampled on the DOT_RR result beat
// phase        out  3       0 IDLE,1 MXV,2 DOT_PAP,3 UPD_XR,4 DOT_RR,5 UPD_P,6 DONE
// rd_valid     out  1       read addresses below are valid this cycle
// a_rd_addr    out  ADDR_W  A memory read address
// p_rd_addr    out  ADDR_W  P memory read address
// ap_rd_addr   out  ADDR_W  AP memory read address
// x_rd_addr    out  ADDR_W  X memory read address
// r_rd_addr    out  ADDR_W  R memory read address
// ap_we/ap_wr_addr out 1/ADDR_W  AP write (MXV results)
// x_we/x_wr_addr   out 1/ADDR_W  X write (UPD_XR results)
// r_we/r_wr_addr   out 1/ADDR_W  R write (UPD_XR results)
// p_we/p_wr_addr   out 1/ADDR_W  P write (UPD_P results)
// iter_count   out  ITER_W  completed iterations
// busy         out  1       phase not IDLE/DONE
// done         out  1       solve finished; held in DONE
// halt_reason  out  1       0 = MAX_ITER reached, 1 = converged; valid while done
// err_res      out  1       sticky: res_valid outside an active phase or beyond expected count
// BEHAVIOUR
// - Reset: phase=IDLE; all addresses, counters, iter_count, rd_valid, *_we, done, halt_reason, err_res = 0.
//   Reset mid-phase aborts immediately; no in-flight result is written after reset.
// - Per active phase: issue counter ic (0..BEATS-1) and result counter rc (0..RES-1), both cleared on entry.
//   rd_valid = (ic<BEATS) && !stall, combinational; ic increments on each rd_valid cycle.
//   Phase exits when ic==BEATS and rc==RES (RES-th result counted); next phase entered next cycle.
//   res_valid and a stall in the same cycle are independent; results are never back-pressured.
// - MXV:     BEATS=N_CLUSTERS, RES=LINES. a_rd_addr=ic; p_rd_addr=ic mod LINES (wraps LINES-1 -> 0).
//            ap_we = res_valid, ap_wr_addr = rc.
// - DOT_PAP: BEATS=LINES, RES=1. p_rd_addr=ap_rd_addr=ic. Scalar result; no memory write.
// - UPD_XR:  BEATS=LINES, RES=LINES. x/r/p/ap_rd_addr=ic. x_we=r_we=res_valid, x_wr_addr=r_wr_addr=rc.
// - DOT_RR:  BEATS=LINES, RES=1. r_rd_addr=ic. On the result beat: if converged -> DONE (halt_reason=1);
//            else if iter_count+1==MAX_ITER -> DONE, iter_count+=1, halt_reason=0; else -> UPD_P.
// - UPD_P:   BEATS=LINES, RES=LINES. p/r_rd_addr=ic. p_we=res_valid, p_wr_addr=rc. Exit: iter_count+=1 -> MXV.
// - *_we are combinational from res_valid and phase; exactly one result per asserted res_valid.
// - Read addresses not used in a phase hold 0. Address outputs zero-extend ic/rc to ADDR_W.
// - IDLE/DONE: start -> MXV, iter_count, done, halt_reason cleared. start while busy ignored.
// - err_res set when res_valid in IDLE/DONE or when rc==RES already; result dropped, no *_we; cleared by reset only.
// - Converged iteration is not counted (iter_count = iterations completing UPD_P).
// TESTING
// T1 defaults (LINES=3), results 2 cycles after each read, converged=0 -> 20 iterations, done=1,
//    iter_count=20, halt_reason=0, exactly 40 A reads and 3 ap_we per MXV.
// T2 converged=1 on DOT_RR result with iter_count=2 -> DONE next cycle, iter_count=2, halt_reason=1, no UPD_P.
// T3 stall pulsed every other cycle in MXV -> a_rd_addr holds while stalled, 40 rd_valid beats, p_rd_addr 0,1,2,0..
// T4 N_EQUATIONS=16 -> LINES=2; UPD_XR x_wr_addr sequence 0,1 only; N_EQUATIONS=17 -> LINES=3.
// T5 reset during UPD_XR after 1 write -> next cycle phase=0, all addrs 0, x_we=0 despite res_valid.
// T6 res_valid in IDLE, and 2nd result in DOT_PAP -> err_res=1, no *_we pulse; start while busy -> no effect.

Source files
------------

// File: rtl/cg_phase_sequencer.sv
// rtl/cg_phase_sequencer.sv - CG iteration phase FSM driving memory addresses and write enables
module cg_phase_sequencer #(
  parameter int NO_OF_UNITS = 8,
  parameter int N_EQUATIONS = 19,
  parameter int N_CLUSTERS  = 40,
  parameter int ADDR_W      = 20,
  parameter int MAX_ITER    = 20,
  parameter int ITER_W      = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              res_valid,
  input  logic              converged,
  output logic [2:0]        phase,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] p_rd_addr,
  output logic [ADDR_W-1:0] ap_rd_addr,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic [ADDR_W-1:0] r_rd_addr,
  output logic              ap_we,
  output logic [ADDR_W-1:0] ap_wr_addr,
  output logic              x_we,
  output logic [ADDR_W-1:0] x_wr_addr,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_wr_addr,
  output logic              p_we,
  output logic [ADDR_W-1:0] p_wr_addr,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              halt_reason,
  output logic              err_res
);

  localparam int LINES = (N_EQUATIONS + NO_OF_UNITS - 1) / NO_OF_UNITS;
  localparam int MAXB  = (N_CLUSTERS > LINES) ? N_CLUSTERS : LINES;
  localparam int CW    = $clog2(MAXB + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MXV   = 3'd1;
  localparam logic [2:0] S_PAP   = 3'd2;
  localparam logic [2:0] S_XR    = 3'd3;
  localparam logic [2:0] S_RR    = 3'd4;
  localparam logic [2:0] S_UPD_P = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        r_phase;
  logic [CW-1:0]     r_ic, r_rc, r_pl;
  logic [ITER_W-1:0] r_iter;
  logic              r_halt, r_err, r_conv;

  logic [CW-1:0]     w_beats, w_res;
  logic              w_active, w_issue, w_res_ok, w_last_res, w_exit, w_conv;
  logic [ITER_W-1:0] w_iter_inc;

  always_comb begin
    w_beats = CW'(LINES);
    w_res   = CW'(LINES);
    if (r_phase == S_MXV) w_beats = CW'(N_CLUSTERS);
    if (r_phase == S_PAP || r_phase == S_RR) w_res = CW'(1);
  end

  assign w_active   = (r_phase >= S_MXV) && (r_phase <= S_UPD_P);
  assign w_issue    = w_active && !reset && (r_ic < w_beats) && !stall;
  assign w_res_ok   = w_active && !reset && res_valid && (r_rc < w_res);
  assign w_last_res = w_res_ok && (r_rc == w_res - CW'(1));
  assign w_exit     = w_active && (r_ic == w_beats) && (w_last_res || (r_rc == w_res));
  // converged is only meaningful on the DOT_RR result beat; keep it if that beat came early
  assign w_conv     = w_last_res ? converged : r_conv;
  assign w_iter_inc = r_iter + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= S_IDLE;
      r_ic    <= '0;
      r_rc    <= '0;
      r_pl    <= '0;
      r_iter  <= '0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
      r_conv  <= 1'b0;
    end else begin
      if (res_valid && (!w_active || (r_rc == w_res))) r_err <= 1'b1;
      if (!w_active) begin
        if (start) begin
          r_phase <= S_MXV;
          r_iter  <= '0;
          r_halt  <= 1'b0;
          r_ic    <= '0;
          r_rc    <= '0;
          r_pl    <= '0;
          r_conv  <= 1'b0;
        end
      end else if (w_exit) begin
        r_ic   <= '0;
        r_rc   <= '0;
        r_pl   <= '0;
        r_conv <= 1'b0;
        case (r_phase)
          S_MXV: r_phase <= S_PAP;
          S_PAP: r_phase <= S_XR;
          S_XR:  r_phase <= S_RR;
          S_RR: begin
            if (w_conv) begin
              r_phase <= S_DONE;
              r_halt  <= 1'b1;
            end else if (w_iter_inc == ITER_W'(MAX_ITER)) begin
              r_phase <= S_DONE;
              r_iter  <= w_iter_inc;
              r_halt  <= 1'b0;
            end else begin
              r_phase <= S_UPD_P;
            end
          end
          default: begin
            r_phase <= S_MXV;
            r_iter  <= w_iter_inc;
          end
        endcase
      end else begin
        if (w_issue) begin
          r_ic <= r_ic + CW'(1);
          r_pl <= (r_pl == CW'(LINES - 1)) ? '0 : r_pl + CW'(1);
        end
        if (w_res_ok) begin
          r_rc <= r_rc + CW'(1);
          if (r_phase == S_RR) r_conv <= converged;
        end
      end
    end
  end

  always_comb begin
    phase       = r_phase;
    busy        = w_active;
    done        = (r_phase == S_DONE);
    halt_reason = r_halt;
    err_res     = r_err;
    iter_count  = r_iter;
    rd_valid    = w_issue;
    a_rd_addr   = '0;
    p_rd_addr   = '0;
    ap_rd_addr  = '0;
    x_rd_addr   = '0;
    r_rd_addr   = '0;
    ap_we       = 1'b0;
    ap_wr_addr  = '0;
    x_we        = 1'b0;
    x_wr_addr   = '0;
    r_we        = 1'b0;
    r_wr_addr   = '0;
    p_we        = 1'b0;
    p_wr_addr   = '0;
    case (r_phase)
      S_MXV: begin
        a_rd_addr  = ADDR_W'(r_ic);
        p_rd_addr  = ADDR_W'(r_pl);
        ap_we      = w_res_ok;
        ap_wr_addr = ADDR_W'(r_rc);
      end
      S_PAP: begin
        p_rd_addr  = ADDR_W'(r_ic);
        ap_rd_addr = ADDR_W'(r_ic);
      end
      S_XR: begin
        x_rd_addr  = ADDR_W'(r_ic);
        r_rd_addr  = ADDR_W'(r_ic);
        p_rd_addr  = ADDR_W'(r_ic);
        ap_rd_addr = ADDR_W'(r_ic);
        x_we       = w_res_ok;
        r_we       = w_res_ok;
        x_wr_addr  = ADDR_W'(r_rc);
        r_wr_addr  = ADDR_W'(r_rc);
      end
      S_RR: r_rd_addr = ADDR_W'(r_ic);
      S_UPD_P: begin
        p_rd_addr = ADDR_W'(r_ic);
        r_rd_addr = ADDR_W'(r_ic);
        p_we      = w_res_ok;
        p_wr_addr = ADDR_W'(r_rc);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// tb/tb_cg_phase_sequencer.sv - randomized bench for cg_phase_sequencer with a phase-level reference model
module tb_cg_phase_sequencer;
  localparam int AW = 20, IW = 11, NC = 40, MAXI = 20;
  localparam logic [2:0] P_IDLE = 0, P_MXV = 1, P_PAP = 2, P_XR = 3, P_RR = 4, P_UP = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start [3], stall [3], res_valid [3], converged [3];
  logic [2:0]    phase [3];
  logic          rd_valid [3];
  logic [AW-1:0] a_rd [3], p_rd [3], ap_rd [3], x_rd [3], r_rd [3];
  logic          ap_we [3], x_we [3], r_we [3], p_we [3];
  logic [AW-1:0] ap_wa [3], x_wa [3], r_wa [3], p_wa [3];
  logic [IW-1:0] iter [3];
  logic          busy [3], done [3], halt [3], err [3];

  // three instances: 19 equations (3 lines), 16 (2 lines), 17 (3 lines)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    cg_phase_sequencer #(
      .NO_OF_UNITS(8), .N_EQUATIONS(g == 0 ? 19 : (g == 1 ? 16 : 17)), .N_CLUSTERS(NC),
      .ADDR_W(AW), .MAX_ITER(MAXI), .ITER_W(IW)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .stall(stall[g]), .res_valid(res_valid[g]),
      .converged(converged[g]), .phase(phase[g]), .rd_valid(rd_valid[g]),
      .a_rd_addr(a_rd[g]), .p_rd_addr(p_rd[g]), .ap_rd_addr(ap_rd[g]), .x_rd_addr(x_rd[g]),
      .r_rd_addr(r_rd[g]), .ap_we(ap_we[g]), .ap_wr_addr(ap_wa[g]), .x_we(x_we[g]),
      .x_wr_addr(x_wa[g]), .r_we(r_we[g]), .r_wr_addr(r_wa[g]), .p_we(p_we[g]),
      .p_wr_addr(p_wa[g]), .iter_count(iter[g]), .busy(busy[g]), .done(done[g]),
      .halt_reason(halt[g]), .err_res(err[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         lines [3] = '{3, 2, 3};
  logic [2:0] m_phase [3];
  int         m_iter [3], reads [3], given [3], dut_reads [3], dut_wr [3], conv_at [3];
  bit         m_err [3], m_halt [3], give [3], inject [3], exp_rv [3], want_start [3];

  function automatic bit is_act(input logic [2:0] ph);
    return (ph >= P_MXV) && (ph <= P_UP);
  endfunction

  function automatic int beats_of(input int g, input logic [2:0] ph);
    return (ph == P_MXV) ? NC : lines[g];
  endfunction

  function automatic int res_of(input int g, input logic [2:0] ph);
    if (ph == P_MXV) return lines[g];
    if (ph == P_PAP || ph == P_RR) return 1;
    return lines[g];
  endfunction

  task automatic cycle(input int stall_pct, input bit inj_en);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      int b, rs, allowed;
      bit act;
      act = is_act(m_phase[g]);
      b = beats_of(g, m_phase[g]);
      rs = res_of(g, m_phase[g]);
      allowed = (rs == b) ? reads[g] : ((reads[g] == b) ? rs : 0);
      stall[g] = ($urandom_range(0, 99) < stall_pct);
      give[g] = act && (given[g] < allowed) && ($urandom_range(0, 1) == 1);
      inject[g] = inj_en && !give[g] && (!act || given[g] == rs) && ($urandom_range(0, 31) == 0);
      res_valid[g] = give[g] || inject[g];
      converged[g] = (give[g] && m_phase[g] == P_RR) ? (m_iter[g] == conv_at[g]) : ($urandom_range(0, 1) == 1);
      start[g] = act ? ($urandom_range(0, 31) == 0) : want_start[g];
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      int b, rs, rb;
      int ea, ep, eap, ex, er;
      bit act;
      act = is_act(m_phase[g]);
      b = beats_of(g, m_phase[g]);
      rs = res_of(g, m_phase[g]);
      exp_rv[g] = act && (reads[g] < b) && !stall[g];
      ea = 0; ep = 0; eap = 0; ex = 0; er = 0;
      case (m_phase[g])
        P_MXV: begin ea = reads[g]; ep = reads[g] % lines[g]; end
        P_PAP: begin ep = reads[g]; eap = reads[g]; end
        P_XR:  begin ex = reads[g]; er = reads[g]; ep = reads[g]; eap = reads[g]; end
        P_RR:  er = reads[g];
        P_UP:  begin ep = reads[g]; er = reads[g]; end
        default: ;
      endcase
      check_eq($sformatf("u%0d.phase", g), phase[g], m_phase[g]);
      check_eq($sformatf("u%0d.rd_valid", g), rd_valid[g], exp_rv[g]);
      check_eq($sformatf("u%0d.a_rd_addr", g), a_rd[g], ea);
      check_eq($sformatf("u%0d.p_rd_addr", g), p_rd[g], ep);
      check_eq($sformatf("u%0d.ap_rd_addr", g), ap_rd[g], eap);
      check_eq($sformatf("u%0d.x_rd_addr", g), x_rd[g], ex);
      check_eq($sformatf("u%0d.r_rd_addr", g), r_rd[g], er);
      check_eq($sformatf("u%0d.ap_we", g), ap_we[g], give[g] && m_phase[g] == P_MXV);
      check_eq($sformatf("u%0d.x_we", g), x_we[g], give[g] && m_phase[g] == P_XR);
      check_eq($sformatf("u%0d.r_we", g), r_we[g], give[g] && m_phase[g] == P_XR);
      check_eq($sformatf("u%0d.p_we", g), p_we[g], give[g] && m_phase[g] == P_UP);
      if (give[g] && m_phase[g] == P_MXV) check_eq($sformatf("u%0d.ap_wr_addr", g), ap_wa[g], given[g]);
      if (give[g] && m_phase[g] == P_XR) begin
        check_eq($sformatf("u%0d.x_wr_addr", g), x_wa[g], given[g]);
        check_eq($sformatf("u%0d.r_wr_addr", g), r_wa[g], given[g]);
      end
      if (give[g] && m_phase[g] == P_UP) check_eq($sformatf("u%0d.p_wr_addr", g), p_wa[g], given[g]);
      check_eq($sformatf("u%0d.iter_count", g), iter[g], m_iter[g]);
      check_eq($sformatf("u%0d.busy", g), busy[g], act);
      check_eq($sformatf("u%0d.done", g), done[g], m_phase[g] == P_DONE);
      check_eq($sformatf("u%0d.err_res", g), err[g], m_err[g]);
      if (m_phase[g] == P_DONE) check_eq($sformatf("u%0d.halt_reason", g), halt[g], m_halt[g]);
      dut_reads[g] += int'(rd_valid[g]);
      dut_wr[g] += int'(ap_we[g] || x_we[g] || r_we[g] || p_we[g]);

      if (inject[g]) m_err[g] = 1'b1;
      if (!act) begin
        if (start[g]) begin
          m_phase[g] = P_MXV; m_iter[g] = 0; m_halt[g] = 1'b0;
          reads[g] = 0; given[g] = 0; dut_reads[g] = 0; dut_wr[g] = 0; want_start[g] = 1'b0;
        end
      end else begin
        rb = reads[g];
        if (exp_rv[g]) reads[g]++;
        if (give[g]) given[g]++;
        if (rb == b && given[g] == rs) begin
          check_eq($sformatf("u%0d.phase_reads", g), dut_reads[g], b);
          check_eq($sformatf("u%0d.phase_writes", g), dut_wr[g],
                   (m_phase[g] == P_PAP || m_phase[g] == P_RR) ? 0 : rs);
          case (m_phase[g])
            P_MXV: m_phase[g] = P_PAP;
            P_PAP: m_phase[g] = P_XR;
            P_XR:  m_phase[g] = P_RR;
            P_RR: begin
              if (m_iter[g] == conv_at[g]) begin m_phase[g] = P_DONE; m_halt[g] = 1'b1; end
              else if (m_iter[g] + 1 == MAXI) begin m_phase[g] = P_DONE; m_iter[g]++; m_halt[g] = 1'b0; end
              else m_phase[g] = P_UP;
            end
            default: begin m_phase[g] = P_MXV; m_iter[g]++; end
          endcase
          reads[g] = 0; given[g] = 0; dut_reads[g] = 0; dut_wr[g] = 0;
        end
      end
    end
  endtask

  task automatic run(input int stall_pct, input bit inj, input int conv_mode, input bit abort);
    int cyc;
    bit all_done, stop;
    for (int g = 0; g < 3; g++) begin
      conv_at[g] = (conv_mode == -2) ? int'($urandom_range(0, 24)) : conv_mode;
      want_start[g] = 1'b1;
    end
    cyc = 0; stop = 1'b0; all_done = 1'b0;
    while (!stop) begin
      cycle(stall_pct, inj);
      cyc++;
      all_done = 1'b1;
      for (int g = 0; g < 3; g++) if (m_phase[g] != P_DONE) all_done = 1'b0;
      if (all_done || cyc >= 30000) stop = 1'b1;
      if (abort && m_phase[0] == P_XR && given[0] >= 1) stop = 1'b1;
    end
    if (!abort) begin
      check_eq("run_done", all_done, 1);
      cycle(stall_pct, 1'b0);
      for (int g = 0; g < 3; g++) begin
        int ef;
        bit eh;
        eh = (conv_at[g] >= 0) && (conv_at[g] < MAXI);
        ef = eh ? conv_at[g] : MAXI;
        check_eq($sformatf("u%0d.final_iter", g), iter[g], ef);
        check_eq($sformatf("u%0d.final_halt", g), halt[g], eh);
        check_eq($sformatf("u%0d.final_done", g), done[g], 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s.u%0d.phase", tag, g), phase[g], P_IDLE);
      check_eq($sformatf("%s.u%0d.rd_valid", tag, g), rd_valid[g], 0);
      check_eq($sformatf("%s.u%0d.rd_addrs", tag, g), a_rd[g] | p_rd[g] | ap_rd[g] | x_rd[g] | r_rd[g], 0);
      check_eq($sformatf("%s.u%0d.wes", tag, g), {ap_we[g], x_we[g], r_we[g], p_we[g]}, 0);
      check_eq($sformatf("%s.u%0d.iter_count", tag, g), iter[g], 0);
      check_eq($sformatf("%s.u%0d.flags", tag, g), {busy[g], done[g], halt[g], err[g]}, 0);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      start[g] = 0; stall[g] = 0; res_valid[g] = 0; converged[g] = 0;
      m_phase[g] = P_IDLE; m_iter[g] = 0; m_err[g] = 0; m_halt[g] = 0;
      reads[g] = 0; given[g] = 0; dut_reads[g] = 0; dut_wr[g] = 0; want_start[g] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_idle_outputs("reset");
    reset = 1'b0;

    run(0, 1'b0, -1, 1'b0);
    run(50, 1'b0, 2, 1'b0);
    run(30, 1'b1, -2, 1'b0);
    run(20, 1'b0, -1, 1'b1);

    // abort in UPD_XR after the first write, with a result still arriving
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 0; stall[g] = 0; res_valid[g] = 1; converged[g] = 0;
    end
    #1 check_eq("abort.x_we_in_reset", x_we[0], 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_idle_outputs("abort");
    @(negedge clk);
    for (int g = 0; g < 3; g++) res_valid[g] = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("idle_res.u%0d.err_res", g), err[g], 1);
      check_eq($sformatf("idle_res.u%0d.wes", g), {ap_we[g], x_we[g], r_we[g], p_we[g]}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
